alu_cmd_responder: RTL and testbench
====================================

ALU_CMD_RESPONDER -- requirements
Module: alu_cmd_responder

Interface
REQ-001 Parameter N, default 32, operand/result width.
REQ-002 Parameter DEPTH, default 4, response queue entries (power of two, >=2).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  command present.
REQ-006 req_ready  out  1  block can accept a command this cycle.
REQ-007 req_op  in  5  aluop code: 00001 ADD, 00010 ADDU, 00011 SUB, 00100 MUL, 00101 SMUL, 00110 DIV, 00111 IDIV, 01000 AND, 01001 OR, 01010 XOR, 01011 NAND, 01100 NOR, 01101 XNOR, 01110 SLL, 01111 SRL, 10000 SAR, 10001 ROR, 10010 ROL.
REQ-008 req_a, req_b  in  N  operands.
REQ-009 req_tag  in  4  requester ID, returned unchanged.
REQ-010 rsp_valid  out  1  head response present.
REQ-011 rsp_ready  in  1  consumer takes the response.
REQ-012 rsp_result  out  N; rsp_cout, rsp_neg, rsp_ovf, rsp_zero  out  1 each; rsp_err  out  1; rsp_tag  out  4.
REQ-013 err_count  out  8  saturating count of errored commands.

Function
REQ-014 A command SHALL be accepted on an edge where req_valid && req_ready.
REQ-015 req_ready SHALL equal (occupancy < DEPTH); no full-queue bypass, even when rsp_ready is high.
REQ-016 An accepted command SHALL be evaluated combinationally by the ALU and its result, flags, err and tag written to the queue tail at the accept edge; rsp_valid SHALL be high from the next cycle (latency 1).
REQ-017 A response SHALL be popped on an edge where rsp_valid && rsp_ready; rsp_* SHALL always reflect the head entry and be stable while rsp_valid && !rsp_ready.
REQ-018 Simultaneous push and pop SHALL leave occupancy unchanged; push into an empty queue with pop absent SHALL give occupancy 1.
REQ-019 Responses SHALL be returned in acceptance order; pointers SHALL wrap modulo DEPTH.
REQ-020 Flags: zero = (result == 0); neg = result[N-1]; cout = carry/borrow out of ADD/ADDU/SUB, else 0; ovf = signed overflow for ADD/SUB, upper-half nonzero (MUL) or not a sign extension (SMUL), else 0.
REQ-021 MUL/SMUL SHALL return the low N bits of the 2N-bit product.
REQ-022 Shift/rotate amount SHALL be req_b[4:0] (log2 N bits in general).
REQ-023 DIV/IDIV with req_b == 0 SHALL return result all ones, err=1, other flags from that result.
REQ-024 Any opcode outside REQ-007 SHALL return result 0, all flags 0, err=1.
REQ-025 err_count SHALL increment on each accepted errored command and hold at 255.

Reset
REQ-026 While rst_n is low: occupancy 0, pointers 0, rsp_valid 0, req_ready 0, err_count 0, queue storage cleared so rsp_* read 0.
REQ-027 Reset asserted mid-operation SHALL discard all queued responses; no response SHALL appear after release without a new accept.
REQ-028 req_ready SHALL rise on the first clock edge after rst_n deasserts.

Structure
REQ-029 Opcode constants, N default and flag bit positions SHALL live in a shared alu_pkg used also by the ALU.
REQ-030 The existing ALU SHALL be instantiated unmodified for arithmetic; the queue SHALL be a sub-module alu_rsp_fifo (width parameterised, DEPTH entries).

Verification
REQ-031 ADD a=-100, b=50 tag 3 -> one cycle later rsp_result=0xFFFFFFCE, neg=1, zero=0, err=0, tag=3.
REQ-032 SUB a=1, b=5 then ADDU a=100, b=50 back-to-back with rsp_ready=1 -> results 0xFFFFFFFC then 150 in order.
REQ-033 rsp_ready=0, issue 5 commands -> first 4 accepted, req_ready low at occupancy 4; raise rsp_ready -> 4 responses in order, fifth then accepted.
REQ-034 DIV a=1, b=0 and opcode 10011 -> both err=1, results 0xFFFFFFFF and 0, err_count=2.
REQ-035 Queue holding 3 entries, pulse rst_n low -> rsp_valid 0 immediately, no stale response after release.
REQ-036 Full queue with req_valid and rsp_ready both high -> pop only that edge, push on the following edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, default width and flag vector layout.
package alu_pkg;

    localparam int ALU_N = 32;
    localparam int TAG_W = 4;

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00001,
        OP_ADDU = 5'b00010,
        OP_SUB  = 5'b00011,
        OP_MUL  = 5'b00100,
        OP_SMUL = 5'b00101,
        OP_DIV  = 5'b00110,
        OP_IDIV = 5'b00111,
        OP_AND  = 5'b01000,
        OP_OR   = 5'b01001,
        OP_XOR  = 5'b01010,
        OP_NAND = 5'b01011,
        OP_NOR  = 5'b01100,
        OP_XNOR = 5'b01101,
        OP_SLL  = 5'b01110,
        OP_SRL  = 5'b01111,
        OP_SAR  = 5'b10000,
        OP_ROR  = 5'b10001,
        OP_ROL  = 5'b10010
    } alu_op_e;

    // Bit positions inside the ALU flag vector.
    localparam int FLAG_COUT = 0;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_ZERO = 3;
    localparam int FLAG_ERR  = 4;
    localparam int FLAG_W    = 5;

endpackage

// File: rtl/alu_cmd_responder_if.sv
// Command/response bus between a requester (master) and the responder (slave).
interface alu_cmd_responder_if
    import alu_pkg::*;
#(
    parameter int N = ALU_N
);
    logic             req_valid;
    logic             req_ready;
    logic [4:0]       req_op;
    logic [N-1:0]     req_a;
    logic [N-1:0]     req_b;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [N-1:0]     rsp_result;
    logic             rsp_cout;
    logic             rsp_neg;
    logic             rsp_ovf;
    logic             rsp_zero;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_cout, rsp_neg,
               rsp_ovf, rsp_zero, rsp_err, rsp_tag
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_cout, rsp_neg,
               rsp_ovf, rsp_zero, rsp_err, rsp_tag
    );
endinterface

// File: rtl/alu.sv
// Combinational ALU: result plus cout/neg/ovf/zero/err flag vector.
module alu
    import alu_pkg::*;
#(
    parameter int N = ALU_N
) (
    input  logic [4:0]        op,
    input  logic [N-1:0]      a,
    input  logic [N-1:0]      b,
    output logic [N-1:0]      result,
    output logic [FLAG_W-1:0] flags
);
    localparam int SW = $clog2(N);

    alu_op_e        op_e;
    logic [SW-1:0]  sh;
    logic [N:0]     add_w;
    logic [N:0]     sub_w;
    logic [2*N-1:0] umul_w;
    logic [2*N-1:0] smul_w;
    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic [N-1:0]   uquo;
    logic [N-1:0]   squo_mag;
    logic [N-1:0]   rot_r;
    logic [N-1:0]   rot_l;
    logic           valid;
    logic           cout;
    logic           ovf;
    logic           err;

    assign op_e   = alu_op_e'(op);
    assign sh     = b[SW-1:0];
    assign add_w  = {1'b0, a} + {1'b0, b};
    assign sub_w  = {1'b0, a} - {1'b0, b};   // top bit is the borrow
    assign umul_w = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    // Low 2N bits of a product of sign-extended operands equal the signed product.
    assign smul_w = {{N{a[N-1]}}, a} * {{N{b[N-1]}}, b};

    // Signed divide via magnitudes keeps truncation toward zero and avoids
    // relying on tool-specific signed division semantics.
    assign a_mag    = a[N-1] ? -a : a;
    assign b_mag    = b[N-1] ? -b : b;
    assign uquo     = (b == '0) ? '1 : a / b;
    assign squo_mag = (b == '0) ? '1 : a_mag / b_mag;

    assign rot_r = N'({a, a} >> sh);
    assign rot_l = N'(({a, a} << sh) >> N);

    // Operation select, then flags derived from the selected result.
    always_comb begin
        result = '0;
        cout   = 1'b0;
        ovf    = 1'b0;
        err    = 1'b0;
        valid  = 1'b1;
        case (op_e)
            OP_ADD: begin
                result = add_w[N-1:0];
                cout   = add_w[N];
                ovf    = (a[N-1] == b[N-1]) && (add_w[N-1] != a[N-1]);
            end
            OP_ADDU: begin
                result = add_w[N-1:0];
                cout   = add_w[N];
            end
            OP_SUB: begin
                result = sub_w[N-1:0];
                cout   = sub_w[N];
                ovf    = (a[N-1] != b[N-1]) && (sub_w[N-1] != a[N-1]);
            end
            OP_MUL: begin
                result = umul_w[N-1:0];
                ovf    = |umul_w[2*N-1:N];
            end
            OP_SMUL: begin
                result = smul_w[N-1:0];
                ovf    = smul_w[2*N-1:N] != {N{smul_w[N-1]}};
            end
            OP_DIV: begin
                result = uquo;
                err    = (b == '0);
            end
            OP_IDIV: begin
                if (b == '0) result = '1;
                else         result = (a[N-1] ^ b[N-1]) ? -squo_mag : squo_mag;
                err = (b == '0);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_XNOR: result = ~(a ^ b);
            OP_SLL:  result = a << sh;
            OP_SRL:  result = a >> sh;
            OP_SAR:  result = $signed(a) >>> sh;
            OP_ROR:  result = rot_r;
            OP_ROL:  result = rot_l;
            default: begin
                valid = 1'b0;
                err   = 1'b1;
            end
        endcase

        flags           = '0;
        flags[FLAG_ERR] = err;
        if (valid) begin
            flags[FLAG_COUT] = cout;
            flags[FLAG_OVF]  = ovf;
            flags[FLAG_NEG]  = result[N-1];
            flags[FLAG_ZERO] = (result == '0);
        end
    end
endmodule

// File: rtl/alu_rsp_fifo.sv
// Response queue: DEPTH entries of W bits, head always visible on dout.
module alu_rsp_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             count;
    logic                    push_ok;
    logic                    pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage is cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       mem <= '0;
        else if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else begin
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/alu_cmd_responder.sv
// Accepts ALU commands, evaluates them at accept time and returns responses in order.
module alu_cmd_responder
    import alu_pkg::*;
#(
    parameter int N     = ALU_N,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_cmd_responder_if.slave   bus,
    output logic [7:0]           err_count
);
    localparam int EW = TAG_W + FLAG_W + N;

    logic [N-1:0]      alu_result;
    logic [FLAG_W-1:0] alu_flags;
    logic [EW-1:0]     head;
    logic              full;
    logic              empty;
    logic              accept;
    logic              take;
    logic              ready_en;

    alu #(.N(N)) u_alu (
        .op     (bus.req_op),
        .a      (bus.req_a),
        .b      (bus.req_b),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // Hold req_ready low through reset and until the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // No full-queue bypass: a pop this edge does not free a slot until the next.
    assign bus.req_ready = ready_en && !full;
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid = !empty;
    assign take          = bus.rsp_valid && bus.rsp_ready;

    alu_rsp_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .din   ({bus.req_tag, alu_flags, alu_result}),
        .pop   (take),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.rsp_result = head[N-1:0];
    assign bus.rsp_cout   = head[N+FLAG_COUT];
    assign bus.rsp_neg    = head[N+FLAG_NEG];
    assign bus.rsp_ovf    = head[N+FLAG_OVF];
    assign bus.rsp_zero   = head[N+FLAG_ZERO];
    assign bus.rsp_err    = head[N+FLAG_ERR];
    assign bus.rsp_tag    = head[EW-1 -: TAG_W];

    // Saturating count of accepted commands that came back with err set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_count <= 8'd0;
        else if (accept && alu_flags[FLAG_ERR] && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
endmodule

// File: tb/tb_alu_cmd_responder.sv
// Directed + random bench for alu_cmd_responder with a queue-based reference model.
module tb_alu_cmd_responder;
    localparam int DEPTH = 4;
    localparam longint MAXI = 2147483647;
    localparam longint MINI = -MAXI - 1;

    typedef struct packed {
        logic [3:0]  tag;
        logic        err;
        logic        zero;
        logic        ovf;
        logic        neg;
        logic        cout;
        logic [31:0] res;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] err_count;
    logic       acc;
    logic       pending;
    int         errors = 0;
    int         checks = 0;
    int         m_errcnt = 0;
    bit         started = 0;
    exp_t       q[$];

    alu_cmd_responder_if #(.N(32)) bus ();

    alu_cmd_responder #(.N(32), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, exp);
        end
    endtask

    // Reference: arithmetic straight from the opcode definitions, using 64-bit math.
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [3:0] tag);
        exp_t        e;
        longint      s;
        logic [63:0] u;
        logic [31:0] r;
        int          sh;
        bit          ok;
        e = '0; e.tag = tag; ok = 1; r = '0; s = 0; u = '0;
        sh = int'(b[4:0]);
        case (op)
            5'd1: begin
                u = {32'd0, a} + {32'd0, b}; r = u[31:0]; e.cout = u[32];
                s = longint'(int'(a)) + longint'(int'(b)); e.ovf = (s > MAXI) || (s < MINI);
            end
            5'd2: begin u = {32'd0, a} + {32'd0, b}; r = u[31:0]; e.cout = u[32]; end
            5'd3: begin
                r = a - b; e.cout = (a < b);
                s = longint'(int'(a)) - longint'(int'(b)); e.ovf = (s > MAXI) || (s < MINI);
            end
            5'd4: begin u = {32'd0, a} * {32'd0, b}; r = u[31:0]; e.ovf = (u[63:32] != 0); end
            5'd5: begin
                s = longint'(int'(a)) * longint'(int'(b)); r = s[31:0];
                e.ovf = (s > MAXI) || (s < MINI);
            end
            5'd6: if (b == 0) begin r = '1; e.err = 1; end else r = a / b;
            5'd7: if (b == 0) begin r = '1; e.err = 1; end else r = 32'(int'(a) / int'(b));
            5'd8:  r = a & b;
            5'd9:  r = a | b;
            5'd10: r = a ^ b;
            5'd11: r = ~(a & b);
            5'd12: r = ~(a | b);
            5'd13: r = ~(a ^ b);
            5'd14: r = a << sh;
            5'd15: r = a >> sh;
            5'd16: r = 32'(int'(a) >>> sh);
            5'd17: begin r = a; repeat (sh) r = {r[0], r[31:1]}; end
            5'd18: begin r = a; repeat (sh) r = {r[30:0], r[31]}; end
            default: ok = 0;
        endcase
        if (ok) begin
            e.res = r; e.zero = (r == 0); e.neg = r[31];
        end else begin
            e = '0; e.tag = tag; e.err = 1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One clock: drive, check outputs against the model mid-cycle, then step the model.
    task automatic cycle(input logic v, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag, input logic rr,
                         input string nm, output logic accd);
        exp_t e, h;
        logic push, pop;
        bus.req_valid = v; bus.req_op = op; bus.req_a = a; bus.req_b = b;
        bus.req_tag = tag; bus.rsp_ready = rr;
        @(negedge clk);
        chk({nm, ":req_ready"}, 64'(bus.req_ready), 64'(started && (q.size() < DEPTH)));
        chk({nm, ":rsp_valid"}, 64'(bus.rsp_valid), 64'(q.size() != 0));
        chk({nm, ":err_count"}, 64'(err_count), 64'(m_errcnt));
        if (q.size() != 0) begin
            h = q[0];
            chk({nm, ":head"}, 64'({bus.rsp_tag, bus.rsp_err, bus.rsp_zero, bus.rsp_ovf,
                                     bus.rsp_neg, bus.rsp_cout, bus.rsp_result}), 64'(h));
        end
        push = v && started && (q.size() < DEPTH);
        pop  = rr && (q.size() != 0);
        e = model(op, a, b, tag);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(e);
            if (e.err && m_errcnt < 255) m_errcnt++;
        end
        started = 1;
        #1;
        accd = push;
    endtask

    task automatic rand_cycles(input int n, input string nm);
        logic [4:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < n; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(19, 31)) : 5'($urandom_range(1, 18));
            a = rnd_operand();
            b = rnd_operand();
            if (op == 5'd7 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            cycle($urandom_range(0, 3) != 0, op, a, b, 4'($urandom), $urandom_range(0, 2) != 0, nm, acc);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_valid = 0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
        bus.req_tag = '0; bus.rsp_ready = 0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst:req_ready", 64'(bus.req_ready), 64'(0));
        chk("rst:rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst:rsp_result", 64'(bus.rsp_result), 64'(0));
        chk("rst:rsp_tag", 64'(bus.rsp_tag), 64'(0));
        chk("rst:err_count", 64'(err_count), 64'(0));
        rst_n = 1'b1;
        #1 chk("rel:req_ready_low", 64'(bus.req_ready), 64'(0));

        // req_ready rises after the first edge following release
        cycle(0, 5'd0, 0, 0, 0, 0, "first_edge", acc);
        chk("first_edge:req_ready", 64'(bus.req_ready), 64'(1));

        // ADD -100 + 50, tag 3: visible one cycle after accept
        cycle(1, 5'd1, 32'hFFFF_FF9C, 32'd50, 4'd3, 0, "add", acc);
        chk("add:valid", 64'(bus.rsp_valid), 64'(1));
        chk("add:result", 64'(bus.rsp_result), 64'(32'hFFFF_FFCE));
        chk("add:neg", 64'(bus.rsp_neg), 64'(1));
        chk("add:zero", 64'(bus.rsp_zero), 64'(0));
        chk("add:err", 64'(bus.rsp_err), 64'(0));
        chk("add:tag", 64'(bus.rsp_tag), 64'(3));
        cycle(0, 5'd0, 0, 0, 0, 1, "add_pop", acc);

        // SUB then ADDU back-to-back while draining
        cycle(1, 5'd3, 32'd1, 32'd5, 4'd1, 1, "sub", acc);
        chk("sub:result", 64'(bus.rsp_result), 64'(32'hFFFF_FFFC));
        cycle(1, 5'd2, 32'd100, 32'd50, 4'd2, 1, "addu", acc);
        chk("addu:result", 64'(bus.rsp_result), 64'(150));
        cycle(0, 5'd0, 0, 0, 0, 1, "drain1", acc);

        // Divide by zero and an undefined opcode
        cycle(1, 5'd6, 32'd1, 32'd0, 4'd5, 1, "div0", acc);
        chk("div0:err", 64'(bus.rsp_err), 64'(1));
        chk("div0:result", 64'(bus.rsp_result), 64'(32'hFFFF_FFFF));
        cycle(1, 5'b10011, 32'd7, 32'd9, 4'd6, 1, "badop", acc);
        chk("badop:err", 64'(bus.rsp_err), 64'(1));
        chk("badop:result", 64'(bus.rsp_result), 64'(0));
        chk("badop:err_count", 64'(err_count), 64'(2));
        cycle(0, 5'd0, 0, 0, 0, 1, "drain2", acc);

        // Fill to DEPTH with rsp_ready low; fifth command must wait
        for (int i = 0; i < 5; i++)
            cycle(1, 5'd1, 32'(i * 7), 32'd10, 4'(i), 0, "fill", acc);
        chk("full:req_ready", 64'(bus.req_ready), 64'(0));
        pending = 1;
        for (int k = 0; k < 12; k++) begin
            cycle(pending, 5'd1, 32'd28, 32'd10, 4'd4, 1, "full_drain", acc);
            if (k == 0) begin
                chk("full_pop:req_ready", 64'(bus.req_ready), 64'(1));
                chk("full_pop:head_tag", 64'(bus.rsp_tag), 64'(1));
            end
            if (acc) pending = 0;
        end
        chk("full_drain:empty", 64'(bus.rsp_valid), 64'(0));

        // Random traffic
        rand_cycles(400, "rand");

        // Saturate err_count
        for (int i = 0; i < 260; i++)
            cycle(1, 5'd0, 32'(i), 32'(i), 4'(i), 1, "sat", acc);
        chk("sat:err_count", 64'(err_count), 64'(255));
        for (int i = 0; i < 6; i++) cycle(0, 5'd0, 0, 0, 0, 1, "drain3", acc);

        // Reset with 3 queued responses
        for (int i = 0; i < 3; i++)
            cycle(1, 5'd9, 32'(i + 1), 32'h100, 4'(i + 8), 0, "prerst", acc);
        chk("prerst:valid", 64'(bus.rsp_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst:rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("midrst:req_ready", 64'(bus.req_ready), 64'(0));
        chk("midrst:rsp_result", 64'(bus.rsp_result), 64'(0));
        chk("midrst:err_count", 64'(err_count), 64'(0));
        q.delete(); m_errcnt = 0; started = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle(0, 5'd0, 0, 0, 0, 1, "postrst", acc);
        chk("postrst:rsp_valid", 64'(bus.rsp_valid), 64'(0));

        rand_cycles(150, "rand2");
        for (int i = 0; i < 6; i++) cycle(0, 5'd0, 0, 0, 0, 1, "final_drain", acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
